// File: rtl/alu_sequencer.sv
// Command-driven sequencer for the 16-bit ALU datapath and accumulator.
// Single-cycle logic/add/sub ops plus iterative shift-add MULT and restoring DIV.
module alu_sequencer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [3:0]   cmd_op,
    input  logic [W-1:0] cmd_operand,
    output logic [W-1:0] acc,
    output logic [W-1:0] rem,
    output logic         carry,
    output logic         err,
    output logic         busy,
    output logic         rsp_valid
);

    localparam int CW = $clog2(W);

    localparam logic [3:0] OP_NOOP  = 4'b0000;
    localparam logic [3:0] OP_RESET = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0011;
    localparam logic [3:0] OP_MULT  = 4'b0100;
    localparam logic [3:0] OP_DIV   = 4'b0101;
    localparam logic [3:0] OP_AND   = 4'b0110;
    localparam logic [3:0] OP_OR    = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1000;
    localparam logic [3:0] OP_NOR   = 4'b1001;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t          state, nextState;
    logic [CW-1:0]   iterCnt;
    logic            accept;
    logic            lastIter;
    logic [2*W-1:0]  work;
    logic [W-1:0]    opB;
    logic [2*W-1:0]  stepResult;

    // One shift-add step on {partial product high, remaining multiplier}.
    function automatic logic [2*W-1:0] mulStep(input logic [2*W-1:0] prod,
                                                input logic [W-1:0]   mcand);
        logic [W:0] sum;
        sum = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, mcand} : {(W+1){1'b0}});
        return {sum, prod[W-1:1]};
    endfunction

    // One restoring-divide step on {partial remainder, dividend/quotient}.
    function automatic logic [2*W-1:0] divStep(input logic [2*W-1:0] rq,
                                                input logic [W-1:0]   divisor);
        logic [W:0] shifted;
        logic [W:0] diff;
        shifted = {rq[2*W-1:W], rq[W-1]};
        diff    = shifted - {1'b0, divisor};
        if (diff[W])
            return {shifted[W-1:0], rq[W-2:0], 1'b0};
        else
            return {diff[W-1:0], rq[W-2:0], 1'b1};
    endfunction

    assign accept     = cmd_valid && cmd_ready;
    assign lastIter   = (iterCnt == CW'(W - 1));
    assign stepResult = (state == MUL) ? mulStep(work, opB) : divStep(work, opB);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= nextState;
    end

    always_comb begin
        nextState = state;
        cmd_ready = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (accept) begin
                    if (cmd_op == OP_MULT)
                        nextState = MUL;
                    else if (cmd_op == OP_DIV && cmd_operand != '0)
                        nextState = DIV;
                end
            end
            MUL, DIV: begin
                busy = 1'b1;
                if (lastIter)
                    nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            iterCnt <= '0;
        else if (state != IDLE)
            iterCnt <= lastIter ? '0 : iterCnt + CW'(1);
    end

    // Shadow operands: acc stays at its pre-command value until completion.
    always_ff @(posedge clk) begin
        if (accept) begin
            work <= {{W{1'b0}}, acc};
            opB  <= cmd_operand;
        end else if (state != IDLE) begin
            work <= stepResult;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc       <= '0;
            rem       <= '0;
            carry     <= 1'b0;
            err       <= 1'b0;
            rsp_valid <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (accept) begin
                case (cmd_op)
                    OP_NOOP: begin
                        carry     <= 1'b0;
                        err       <= 1'b0;
                        rsp_valid <= 1'b1;
                    end
                    OP_RESET: begin
                        acc       <= '0;
                        rem       <= '0;
                        carry     <= 1'b0;
                        err       <= 1'b0;
                        rsp_valid <= 1'b1;
                    end
                    OP_ADD: begin
                        {carry, acc} <= {1'b0, acc} + {1'b0, cmd_operand};
                        err          <= 1'b0;
                        rsp_valid    <= 1'b1;
                    end
                    OP_SUB: begin
                        acc       <= acc - cmd_operand;
                        carry     <= (acc < cmd_operand);
                        err       <= 1'b0;
                        rsp_valid <= 1'b1;
                    end
                    OP_MULT: ;
                    OP_DIV: begin
                        // Divide by zero answers immediately; otherwise wait for completion.
                        if (cmd_operand == '0) begin
                            err       <= 1'b1;
                            carry     <= 1'b0;
                            rsp_valid <= 1'b1;
                        end
                    end
                    OP_AND, OP_OR, OP_NOT, OP_NOR: begin
                        case (cmd_op)
                            OP_AND:  acc <= acc & cmd_operand;
                            OP_OR:   acc <= acc | cmd_operand;
                            OP_NOT:  acc <= ~acc;
                            default: acc <= ~(acc | cmd_operand);
                        endcase
                        carry     <= 1'b0;
                        err       <= 1'b0;
                        rsp_valid <= 1'b1;
                    end
                    default: begin
                        err       <= 1'b1;
                        rsp_valid <= 1'b1;
                    end
                endcase
            end else if (state != IDLE && lastIter) begin
                acc       <= stepResult[W-1:0];
                err       <= 1'b0;
                rsp_valid <= 1'b1;
                if (state == MUL) begin
                    carry <= |stepResult[2*W-1:W];
                end else begin
                    rem   <= stepResult[2*W-1:W];
                    carry <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed plus short random bench for alu_sequencer with a response scoreboard.
module tb_alu_sequencer;

    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] acc;
        logic [W-1:0] rem;
        logic         carry;
        logic         err;
    } rsp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [3:0]   cmd_op = 4'h0;
    logic [W-1:0] cmd_operand = '0;
    logic [W-1:0] acc;
    logic [W-1:0] rem;
    logic         carry;
    logic         err;
    logic         busy;
    logic         rsp_valid;

    int total = 0;
    int bad = 0;
    int rspCount = 0;
    int rspBefore;

    rsp_t expQ[$];
    rsp_t monExp;

    logic [W-1:0] mAcc = '0;
    logic [W-1:0] mRem = '0;
    logic         mCarry = 1'b0;
    logic         mErr = 1'b0;

    alu_sequencer #(.W(W)) dut (
        .clk(clk),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_operand(cmd_operand),
        .acc(acc),
        .rem(rem),
        .carry(carry),
        .err(err),
        .busy(busy),
        .rsp_valid(rsp_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [3:0] op, input logic [W-1:0] b);
        logic [W:0]     s;
        logic [2*W-1:0] p;
        logic [W-1:0]   q;
        logic [W-1:0]   r;
        case (op)
            4'h0: begin mCarry = 1'b0; mErr = 1'b0; end
            4'h1: begin mAcc = '0; mRem = '0; mCarry = 1'b0; mErr = 1'b0; end
            4'h2: begin
                s = {1'b0, mAcc} + {1'b0, b};
                mAcc = s[W-1:0]; mCarry = s[W]; mErr = 1'b0;
            end
            4'h3: begin mCarry = (mAcc < b); mAcc = mAcc - b; mErr = 1'b0; end
            4'h4: begin
                p = {{W{1'b0}}, mAcc} * {{W{1'b0}}, b};
                mAcc = p[W-1:0]; mCarry = (p[2*W-1:W] != '0); mErr = 1'b0;
            end
            4'h5: begin
                if (b == '0) begin
                    mErr = 1'b1; mCarry = 1'b0;
                end else begin
                    q = mAcc / b; r = mAcc % b;
                    mAcc = q; mRem = r; mCarry = 1'b0; mErr = 1'b0;
                end
            end
            4'h6: begin mAcc = mAcc & b; mCarry = 1'b0; mErr = 1'b0; end
            4'h7: begin mAcc = mAcc | b; mCarry = 1'b0; mErr = 1'b0; end
            4'h8: begin mAcc = ~mAcc; mCarry = 1'b0; mErr = 1'b0; end
            4'h9: begin mAcc = ~(mAcc | b); mCarry = 1'b0; mErr = 1'b0; end
            default: mErr = 1'b1;
        endcase
        expQ.push_back({mAcc, mRem, mCarry, mErr});
    endtask

    task automatic issue(input logic [3:0] op, input logic [W-1:0] b);
        int n;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_wait", {31'b0, cmd_ready}, 32'd1);
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_operand = b;
        model(op, b);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic waitRsp();
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 64) begin
            @(negedge clk); #1;
            n++;
        end
        chk("rsp_drain", expQ.size(), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1 && rsp_valid === 1'b1) begin
            rspCount++;
            total++;
            assert (expQ.size() > 0) else begin
                bad++;
                $error("FAIL unexpected_rsp observed=rsp_valid expected=no_response");
            end
            if (expQ.size() > 0) begin
                monExp = expQ.pop_front();
                total++;
                assert ({acc, rem, carry, err} === monExp) else begin
                    bad++;
                    $error("FAIL rsp_fields observed=%h/%h/%b/%b expected=%h/%h/%b/%b",
                           acc, rem, carry, err, monExp.acc, monExp.rem, monExp.carry, monExp.err);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Asynchronous reset with no clock edge involved.
        #1 rst = 1'b0;
        #1;
        chk("rst_acc", {16'b0, acc}, 32'h0);
        chk("rst_rem", {16'b0, rem}, 32'h0);
        chk("rst_flags", {28'b0, carry, err, busy, rsp_valid}, 32'h0);
        chk("rst_ready", {31'b0, cmd_ready}, 32'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // ADD pair, back to back
        issue(4'h2, 16'h0005);
        chk("add1_rsp", {31'b0, rsp_valid}, 32'd1);
        chk("add1_acc", {16'b0, acc}, 32'h0005);
        issue(4'h2, 16'hFFFD);
        chk("add2_rsp", {31'b0, rsp_valid}, 32'd1);
        chk("add2_acc", {16'b0, acc}, 32'h0002);
        chk("add2_carry", {31'b0, carry}, 32'd1);
        @(posedge clk); #1;
        chk("add_pulse_end", {31'b0, rsp_valid}, 32'd0);

        // SUB with borrow, then NOT
        issue(4'h1, 16'h0000);
        issue(4'h2, 16'h0003);
        issue(4'h3, 16'h0005);
        chk("sub_acc", {16'b0, acc}, 32'hFFFE);
        chk("sub_carry_err", {30'b0, carry, err}, 32'h2);
        issue(4'h8, 16'h1234);
        chk("not_acc", {16'b0, acc}, 32'h0001);
        chk("not_carry", {31'b0, carry}, 32'd0);

        // MULT overflow with latency and busy window
        issue(4'h1, 16'h0000);
        issue(4'h2, 16'h0100);
        issue(4'h4, 16'h0300);
        for (int i = 0; i < W; i++) begin
            chk("mul_busy", {31'b0, busy}, 32'd1);
            chk("mul_ready", {31'b0, cmd_ready}, 32'd0);
            chk("mul_acc_hold", {16'b0, acc}, 32'h0100);
            chk("mul_no_rsp", {31'b0, rsp_valid}, 32'd0);
            @(posedge clk); #1;
        end
        chk("mul_done_rsp", {31'b0, rsp_valid}, 32'd1);
        chk("mul_done_busy", {31'b0, busy}, 32'd0);
        chk("mul_done_ready", {31'b0, cmd_ready}, 32'd1);
        chk("mul_acc", {16'b0, acc}, 32'h0000);
        chk("mul_carry", {31'b0, carry}, 32'd1);

        // DIV, then divide by zero
        issue(4'h1, 16'h0000);
        issue(4'h2, 16'h0064);
        issue(4'h5, 16'h0007);
        waitRsp();
        chk("div_acc", {16'b0, acc}, 32'h000E);
        chk("div_rem", {16'b0, rem}, 32'h0002);
        chk("div_err", {31'b0, err}, 32'd0);
        issue(4'h5, 16'h0000);
        chk("div0_rsp", {31'b0, rsp_valid}, 32'd1);
        chk("div0_err", {31'b0, err}, 32'd1);
        chk("div0_acc_rem", {acc, rem}, 32'h000E_0002);
        chk("div0_ready", {31'b0, cmd_ready}, 32'd1);

        // Illegal opcode, then AND clears err
        issue(4'h1, 16'h0000);
        issue(4'h2, 16'h00AA);
        issue(4'hC, 16'h5555);
        chk("ill_rsp", {31'b0, rsp_valid}, 32'd1);
        chk("ill_err", {31'b0, err}, 32'd1);
        chk("ill_acc", {16'b0, acc}, 32'h00AA);
        issue(4'h6, 16'h000F);
        chk("and_acc", {16'b0, acc}, 32'h000A);
        chk("and_err", {31'b0, err}, 32'd0);

        // Random mix of all opcodes, scoreboard checks every response
        for (int i = 0; i < 30; i++) begin
            logic [3:0]   rop;
            logic [W-1:0] rb;
            rop = 4'($urandom_range(0, 15));
            rb  = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom);
            issue(rop, rb);
        end
        waitRsp();

        // Reset during MULT iteration
        issue(4'h1, 16'h0000);
        issue(4'h2, 16'h0100);
        issue(4'h4, 16'h0300);
        repeat (7) @(posedge clk);
        #1 rst = 1'b0;
        expQ.delete();
        mAcc = '0; mRem = '0; mCarry = 1'b0; mErr = 1'b0;
        #1;
        chk("mrst_acc_rem", {acc, rem}, 32'h0);
        chk("mrst_flags", {28'b0, carry, err, busy, rsp_valid}, 32'h0);
        chk("mrst_ready", {31'b0, cmd_ready}, 32'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        rspBefore = rspCount;
        repeat (30) @(posedge clk);
        #1;
        chk("mrst_no_rsp", rspCount, rspBefore);
        chk("mrst_ready_after", {31'b0, cmd_ready}, 32'd1);
        issue(4'h2, 16'h0007);
        chk("post_rst_acc", {16'b0, acc}, 32'h0007);
        waitRsp();

        chk("queue_empty", expQ.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
